// File: rtl/multicycle_control_unit.sv
// Multicycle sequencer FETCH/DECODE/EXEC/MEM/WB; retire in 2 (nop) to 5 (ld) cycles; requests held until ack, with a timeout trap.
// Optional PERF_CNT_EN adds cycle_cnt/retired_cnt counters; illegal opcodes and memory timeouts park the FSM in ERROR.
module multicycle_control_unit #(
  parameter int OP_W        = 6,
  parameter int ALU_OP_W    = 4,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  output logic                imem_req,
  input  logic                imem_ack,
  input  logic [OP_W-1:0]     op,
  output logic                ir_load,
  output logic                dmem_req,
  output logic                dmem_we,
  input  logic                dmem_ack,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                alu_src,
  input  logic                br_cond,
  output logic                reg_write,
  output logic [1:0]          wb_sel,
  output logic                pc_en,
  output logic [1:0]          pc_sel,
  output logic [2:0]          state,
  output logic                illegal,
`ifdef PERF_CNT_EN
  output logic [CNT_W-1:0]    cycle_cnt,
  output logic [CNT_W-1:0]    retired_cnt,
`endif
  output logic                timeout
);

  // ALU encoding shared with the datapath ALU
  localparam logic [ALU_OP_W-1:0] ALU_NOP = ALU_OP_W'(0);
  localparam logic [ALU_OP_W-1:0] ALU_ADD = ALU_OP_W'(1);
  localparam logic [ALU_OP_W-1:0] ALU_SUB = ALU_OP_W'(2);
  localparam logic [ALU_OP_W-1:0] ALU_AND = ALU_OP_W'(3);
  localparam logic [ALU_OP_W-1:0] ALU_OR  = ALU_OP_W'(4);
  localparam logic [ALU_OP_W-1:0] ALU_XOR = ALU_OP_W'(5);
  localparam logic [ALU_OP_W-1:0] ALU_SLL = ALU_OP_W'(6);
  localparam logic [ALU_OP_W-1:0] ALU_SRL = ALU_OP_W'(7);
  localparam logic [ALU_OP_W-1:0] ALU_SRA = ALU_OP_W'(8);
  localparam logic [ALU_OP_W-1:0] ALU_SLT = ALU_OP_W'(9);

  localparam bit             TO_EN  = (MEM_TIMEOUT > 0);
  localparam int             TW     = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TW-1:0]  TO_LIM = TW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
    S_MEM = 3'd4, S_WB = 3'd5, S_ERROR = 3'd7
  } state_e;

  typedef enum logic [2:0] {
    CL_ALU, CL_LD, CL_ST, CL_BR, CL_JAL, CL_JALR, CL_NOP
  } cls_e;

  state_e                state_q, state_d;
  cls_e                  cls_q, cls_d, dec_cls;
  logic [OP_W-1:0]       op_q, op_d;
  logic [ALU_OP_W-1:0]   alu_op_q, alu_op_d, dec_alu;
  logic                  alu_src_q, alu_src_d, dec_src;
  logic [1:0]            wb_sel_q, wb_sel_d, dec_wb;
  logic [TW-1:0]         wait_q, wait_d;
  logic                  illegal_q, illegal_d, timeout_q, timeout_d;
  logic                  dec_illegal, retire, wait_expired;

  always_comb begin
    dec_alu     = ALU_NOP;
    dec_src     = 1'b0;
    dec_wb      = 2'd0;
    dec_cls     = CL_ALU;
    dec_illegal = (op_q > OP_W'(19));
    case (op_q[4:0])
      5'h00: dec_alu = ALU_ADD;
      5'h01: begin dec_alu = ALU_ADD; dec_src = 1'b1; end
      5'h02: dec_alu = ALU_SUB;
      5'h03: dec_alu = ALU_AND;
      5'h04: begin dec_alu = ALU_AND; dec_src = 1'b1; end
      5'h05: dec_alu = ALU_OR;
      5'h06: begin dec_alu = ALU_OR; dec_src = 1'b1; end
      5'h07: dec_alu = ALU_XOR;
      5'h08: dec_alu = ALU_SLL;
      5'h09: dec_alu = ALU_SRL;
      5'h0A: dec_alu = ALU_SRA;
      5'h0B: begin dec_alu = ALU_ADD; dec_src = 1'b1; dec_wb = 2'd1; dec_cls = CL_LD; end
      5'h0C: begin dec_alu = ALU_ADD; dec_src = 1'b1; dec_cls = CL_ST; end
      5'h0D, 5'h0E: begin dec_alu = ALU_SUB; dec_cls = CL_BR; end
      5'h0F, 5'h10: begin dec_alu = ALU_SLT; dec_cls = CL_BR; end
      5'h11: begin dec_alu = ALU_ADD; dec_src = 1'b1; dec_wb = 2'd2; dec_cls = CL_JAL; end
      5'h12: begin dec_alu = ALU_ADD; dec_src = 1'b1; dec_wb = 2'd2; dec_cls = CL_JALR; end
      default: dec_cls = CL_NOP;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    alu_op_d     = alu_op_q;
    alu_src_d    = alu_src_q;
    wb_sel_d     = wb_sel_q;
    cls_d        = cls_q;
    wait_d       = wait_q;
    illegal_d    = illegal_q;
    timeout_d    = timeout_q;
    retire       = 1'b0;
    imem_req     = 1'b0;
    ir_load      = 1'b0;
    dmem_req     = 1'b0;
    dmem_we      = 1'b0;
    alu_op       = ALU_NOP;
    alu_src      = 1'b0;
    reg_write    = 1'b0;
    wb_sel       = 2'd0;
    pc_en        = 1'b0;
    pc_sel       = 2'd0;
    wait_expired = TO_EN && (wait_q == TO_LIM);
    case (state_q)
      S_IDLE: if (run) begin
        state_d = S_FETCH;
        wait_d  = '0;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        ir_load  = imem_ack;
        if (imem_ack) begin
          op_d    = op;
          state_d = S_DECODE;
        end else if (wait_expired) begin
          state_d   = S_ERROR;
          timeout_d = 1'b1;
        end else if (TO_EN) begin
          wait_d = wait_q + TW'(1);
        end
      end
      S_DECODE: begin
        alu_op_d  = dec_alu;
        alu_src_d = dec_src;
        wb_sel_d  = dec_wb;
        cls_d     = dec_cls;
        if (dec_illegal) begin
          state_d   = S_ERROR;
          illegal_d = 1'b1;
        end else if (dec_cls == CL_NOP) begin
          pc_en  = 1'b1;
          retire = 1'b1;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_op  = alu_op_q;
        alu_src = alu_src_q;
        case (cls_q)
          CL_LD, CL_ST: begin
            state_d = S_MEM;
            wait_d  = '0;
          end
          // Branches resolve on the live compare result, so pc_sel is combinational here
          CL_BR: begin
            pc_en  = 1'b1;
            pc_sel = br_cond ? 2'd1 : 2'd0;
            retire = 1'b1;
          end
          default: state_d = S_WB;
        endcase
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (cls_q == CL_ST);
        if (dmem_ack) begin
          if (cls_q == CL_ST) begin
            pc_en  = 1'b1;
            retire = 1'b1;
          end else begin
            state_d = S_WB;
          end
        end else if (wait_expired) begin
          state_d   = S_ERROR;
          timeout_d = 1'b1;
        end else if (TO_EN) begin
          wait_d = wait_q + TW'(1);
        end
      end
      S_WB: begin
        reg_write = 1'b1;
        wb_sel    = wb_sel_q;
        pc_en     = 1'b1;
        pc_sel    = (cls_q == CL_JAL) ? 2'd2 : (cls_q == CL_JALR) ? 2'd3 : 2'd0;
        retire    = 1'b1;
      end
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_ERROR;
    endcase
    if (retire) begin
      state_d = run ? S_FETCH : S_IDLE;
      wait_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      alu_op_q  <= ALU_NOP;
      alu_src_q <= 1'b0;
      wb_sel_q  <= 2'd0;
      cls_q     <= CL_ALU;
      wait_q    <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      alu_op_q  <= alu_op_d;
      alu_src_q <= alu_src_d;
      wb_sel_q  <= wb_sel_d;
      cls_q     <= cls_d;
      wait_q    <= wait_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
    end
  end

  assign state   = state_q;
  assign illegal = illegal_q;
  assign timeout = timeout_q;

`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d, retired_cnt_q, retired_cnt_d;

  always_comb begin
    cycle_cnt_d   = cycle_cnt_q;
    retired_cnt_d = retired_cnt_q;
    if (state_q != S_IDLE && state_q != S_ERROR) cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
    if (pc_en) retired_cnt_d = retired_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt_q   <= '0;
      retired_cnt_q <= '0;
    end else begin
      cycle_cnt_q   <= cycle_cnt_d;
      retired_cnt_q <= retired_cnt_d;
    end
  end

  assign cycle_cnt   = cycle_cnt_q;
  assign retired_cnt = retired_cnt_q;
`else
  // Keeps CNT_W referenced when the counters are compiled out
  logic [CNT_W-1:0] unused_cnt_w;
  assign unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit with MEM_TIMEOUT=4; counter checks only when PERF_CNT_EN is defined.
module tb_multicycle_control_unit;

  logic       clk = 1'b0;
  logic       rst_n, run, imem_ack, dmem_ack, br_cond;
  logic [5:0] op;
  logic       imem_req, ir_load, dmem_req, dmem_we, alu_src, reg_write, pc_en, illegal, timeout;
  logic [3:0] alu_op;
  logic [1:0] wb_sel, pc_sel;
  logic [2:0] state;
`ifdef PERF_CNT_EN
  logic [31:0] cycle_cnt, retired_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  int         ret_cyc, rw_cnt, dreq_cnt, il_cnt;
  logic [1:0] wbs, pcs;
  logic       dwe, ex_src;
  logic [3:0] ex_alu;

  always #5 clk = ~clk;

  multicycle_control_unit #(.OP_W(6), .ALU_OP_W(4), .MEM_TIMEOUT(4), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .imem_req(imem_req), .imem_ack(imem_ack), .op(op), .ir_load(ir_load),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .alu_op(alu_op), .alu_src(alu_src), .br_cond(br_cond),
    .reg_write(reg_write), .wb_sel(wb_sel), .pc_en(pc_en), .pc_sel(pc_sel),
    .state(state), .illegal(illegal),
`ifdef PERF_CNT_EN
    .cycle_cnt(cycle_cnt), .retired_cnt(retired_cnt),
`endif
    .timeout(timeout)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; run = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0; br_cond = 1'b0; op = 6'h00;
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  // One instruction from IDLE with zero-wait fetch; dmem_ack arrives after dwait MEM wait cycles
  task automatic do_instr(input logic [5:0] opc, input int dwait, input logic br);
    ret_cyc = 0; rw_cnt = 0; dreq_cnt = 0; il_cnt = 0;
    wbs = 2'd0; pcs = 2'd0; dwe = 1'b0; ex_alu = 4'd0; ex_src = 1'b0;
    run = 1'b1; op = opc; br_cond = br;
    cyc();
    for (int i = 1; i <= 14; i++) begin
      imem_ack = (i == 1);
      dmem_ack = (i == 4 + dwait);
      run = 1'b0;
      #1;
      if (pc_en && ret_cyc == 0) begin ret_cyc = i; pcs = pc_sel; end
      if (reg_write) begin rw_cnt++; wbs = wb_sel; end
      if (state == 3'd3) begin ex_alu = alu_op; ex_src = alu_src; end
      dreq_cnt += int'(dmem_req);
      il_cnt   += int'(ir_load);
      dwe      |= dmem_we;
      cyc();
    end
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
  endtask

  task automatic do_illegal(input logic [5:0] opc);
    int busy;
    busy = 0;
    run = 1'b1;
    cyc();
    imem_ack = 1'b1; op = opc;
    cyc();
    cyc();
    #1;
    chk($sformatf("ill_state_%0h", opc), state, 3'd7);
    chk($sformatf("ill_flag_%0h", opc), illegal, 1'b1);
    for (int i = 0; i < 20; i++) begin
      #1;
      busy += int'(imem_req) + int'(dmem_req) + int'(pc_en) + int'(reg_write);
      cyc();
    end
    chk($sformatf("ill_quiet_%0h", opc), busy, 0);
    chk($sformatf("ill_sticky_%0h", opc), state, 3'd7);
    rst_n = 1'b0;
    #1;
    chk($sformatf("ill_rst_state_%0h", opc), state, 3'd0);
    chk($sformatf("ill_rst_flag_%0h", opc), illegal, 1'b0);
    cyc();
    imem_ack = 1'b0;
    run = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    do_reset();
    #1;
    chk("rst_state", state, 3'd0);
    chk("rst_imem_req", imem_req, 1'b0);
    chk("rst_dmem_req", dmem_req, 1'b0);
    chk("rst_alu_op", alu_op, 4'd0);
    chk("rst_strobes", {reg_write, pc_en, illegal, timeout}, 4'b0000);
    cyc();

    do_instr(6'h00, 0, 1'b0);
    chk("add_retire", ret_cyc, 4);
    chk("add_rw", rw_cnt, 1);
    chk("add_alu", ex_alu, 4'd1);
    chk("add_src", ex_src, 1'b0);
    chk("add_wbsel", wbs, 2'd0);
    chk("add_pcsel", pcs, 2'd0);
    chk("add_irload", il_cnt, 1);
    chk("add_idle", state, 3'd0);
    chk("idle_alu_nop", alu_op, 4'd0);

    do_instr(6'h0B, 3, 1'b0);
    chk("ld_retire", ret_cyc, 8);
    chk("ld_dreq", dreq_cnt, 4);
    chk("ld_we", dwe, 1'b0);
    chk("ld_rw", rw_cnt, 1);
    chk("ld_wbsel", wbs, 2'd1);
    chk("ld_src", ex_src, 1'b1);

    do_instr(6'h0D, 0, 1'b1);
    chk("beq_t_retire", ret_cyc, 3);
    chk("beq_t_pcsel", pcs, 2'd1);
    chk("beq_t_rw", rw_cnt, 0);
    do_instr(6'h0D, 0, 1'b0);
    chk("beq_n_retire", ret_cyc, 3);
    chk("beq_n_pcsel", pcs, 2'd0);

    do_instr(6'h0C, 0, 1'b0);
    chk("stw_retire", ret_cyc, 4);
    chk("stw_dreq", dreq_cnt, 1);
    chk("stw_we", dwe, 1'b1);
    chk("stw_rw", rw_cnt, 0);

    do_instr(6'h11, 0, 1'b0);
    chk("jal_pcsel", pcs, 2'd2);
    chk("jal_wbsel", wbs, 2'd2);
    do_instr(6'h12, 0, 1'b0);
    chk("jalr_retire", ret_cyc, 4);
    chk("jalr_pcsel", pcs, 2'd3);
    do_instr(6'h13, 0, 1'b0);
    chk("nop_retire", ret_cyc, 2);
    chk("nop_rw", rw_cnt, 0);
    do_instr(6'h0A, 0, 1'b0);
    chk("sra_alu", ex_alu, 4'd8);
    chk("sra_src", ex_src, 1'b0);
    do_instr(6'h06, 0, 1'b0);
    chk("ori_alu", ex_alu, 4'd4);
    chk("ori_src", ex_src, 1'b1);

    do_illegal(6'h3F);
    do_illegal(6'h14);

    // fetch timeout: ack never arrives
    do_reset();
    run = 1'b1;
    cyc();
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      cnt += int'(imem_req);
      cyc();
    end
    chk("ito_req_cycles", cnt, 4);
    chk("ito_state", state, 3'd7);
    chk("ito_flag", timeout, 1'b1);
    chk("ito_no_illegal", illegal, 1'b0);

    // data timeout: load whose ack never arrives
    do_reset();
    do_instr(6'h0B, 100, 1'b0);
    chk("dto_req_cycles", dreq_cnt, 4);
    chk("dto_no_retire", ret_cyc, 0);
    chk("dto_state", state, 3'd7);
    chk("dto_flag", timeout, 1'b1);

    // reset while a store waits in MEM
    do_reset();
    run = 1'b1;
    cyc();
    imem_ack = 1'b1; op = 6'h0C; run = 1'b0;
    cyc();
    imem_ack = 1'b0;
    cyc();
    cyc();
    #1;
    chk("stw_mem_req", {dmem_req, dmem_we}, 2'b11);
    rst_n = 1'b0;
    #1;
    chk("stw_rst_drop", {dmem_req, dmem_we, pc_en}, 3'b000);
    chk("stw_rst_state", state, 3'd0);
    cyc();
    rst_n = 1'b1;

`ifdef PERF_CNT_EN
    do_reset();
    #1;
    chk("perf_rst", {cycle_cnt, retired_cnt}, 64'd0);
    run = 1'b1;
    cyc();
    for (int i = 1; i <= 20; i++) begin
      imem_ack = 1'b1; op = 6'h13; run = (i < 20);
      cyc();
    end
    imem_ack = 1'b0;
    #1;
    chk("perf_idle", state, 3'd0);
    chk("perf_retired", retired_cnt, 32'd10);
    chk("perf_cycles", cycle_cnt, 32'd20);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
